demux_1x6_dist: RTL and testbench

DEMUX_1X6_DIST -- requirements
Module: demux_1x6_dist

---
 rtl/demux_1x6_dist_pkg.sv | 16 +
 rtl/demux_1x6_dist_chan_hold.sv | 45 ++++
 rtl/demux_1x6_dist.sv | 81 ++++++++
 tb/tb_demux_1x6_dist.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_1x6_dist_pkg.sv
// rtl/demux_1x6_dist_pkg.sv - shared constants and mode encodings for the 1x6 distributor
package demux_1x6_dist_pkg;

    localparam int NUM_CH = 6;
    localparam int SEL_W  = 3;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_RR     = 1'b1
    } mode_e;

    function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] ptr);
        return (ptr == SEL_W'(NUM_CH - 1)) ? '0 : ptr + 1'b1;
    endfunction

endpackage

// File: rtl/demux_1x6_dist_chan_hold.sv
// rtl/demux_1x6_dist_chan_hold.sv - one-entry holding register for a single output channel
module chan_hold #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              drain,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              free
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Drain is applied before load so a full, draining register takes a new beat without a bubble.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && drain) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign free  = ~valid_q | drain;

endmodule

// File: rtl/demux_1x6_dist.sv
// rtl/demux_1x6_dist.sv - 1-to-6 stream distributor with directed and round-robin routing
module demux_1x6_dist
    import demux_1x6_dist_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     sel_err,
    output logic [SEL_W-1:0]         rr_ptr
);

    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              sel_err_q, sel_err_d;
    logic [SEL_W-1:0]  target;
    logic              sel_oob;
    logic              target_free;
    logic              accept;
    logic [NUM_CH-1:0] chan_free;
    logic [NUM_CH-1:0] chan_load;

    // While in reset every channel is treated as empty; accept is still gated so nothing loads.
    always_comb begin
        target      = (mode == MODE_RR) ? rr_ptr_q : sel;
        sel_oob     = (mode == MODE_DIRECT) && (sel >= SEL_W'(NUM_CH));
        target_free = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (target == SEL_W'(k)) begin
                target_free = chan_free[k] | ~rst_n;
            end
        end
        in_ready  = sel_oob | target_free;
        accept    = in_valid & in_ready & rst_n;
        chan_load = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            chan_load[k] = accept & ~sel_oob & (target == SEL_W'(k));
        end
        sel_err_d = accept & sel_oob;
        rr_ptr_d  = rr_ptr_q;
        if (accept && (mode == MODE_RR)) begin
            rr_ptr_d = rr_next(rr_ptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            sel_err_q <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign rr_ptr  = rr_ptr_q;
    assign sel_err = sel_err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        chan_hold #(
            .DATA_W(DATA_W)
        ) u_chan_hold (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (chan_load[g]),
            .load_data(in_data),
            .drain    (out_ready[g]),
            .valid    (out_valid[g]),
            .data     (out_data[g*DATA_W +: DATA_W]),
            .free     (chan_free[g])
        );
    end

endmodule

// File: tb/tb_demux_1x6_dist.sv
// tb/tb_demux_1x6_dist.sv - self-checking bench for demux_1x6_dist
module tb_demux_1x6_dist;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          mode;
    logic [2:0]    sel;
    logic [5:0]    out_valid;
    logic [5:0]    out_ready;
    logic [6*DW-1:0] out_data;
    logic          sel_err;
    logic [2:0]    rr_ptr;

    demux_1x6_dist #(.DATA_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .mode     (mode),
        .sel      (sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .sel_err  (sel_err),
        .rr_ptr   (rr_ptr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: occupancy and last-written payload per channel, beat count for round-robin.
    bit          m_full[6];
    logic [DW-1:0] m_last[6];
    int          m_ptr;
    bit          m_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        int tgt;
        bit oob, exp_rdy, acc;
        @(negedge clk);
        oob = (mode == 1'b0) && (sel >= 3'd6);
        tgt = mode ? m_ptr : int'(sel);
        if (!rst_n || oob) exp_rdy = 1'b1;
        else               exp_rdy = !m_full[tgt] || out_ready[tgt];
        if (chk_en) begin
            for (int k = 0; k < 6; k++) begin
                check("model_out_valid", 64'(out_valid[k]), 64'(m_full[k]));
                check("model_out_data", 64'(out_data[k*DW +: DW]), 64'(m_last[k]));
            end
            check("model_rr_ptr", 64'(rr_ptr), 64'(m_ptr));
            check("model_sel_err", 64'(sel_err), 64'(m_err));
            check("model_in_ready", 64'(in_ready), 64'(exp_rdy));
        end
        acc = rst_n && in_valid && exp_rdy;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            for (int k = 0; k < 6; k++) begin
                m_full[k] = 1'b0;
                m_last[k] = '0;
            end
            m_ptr = 0;
            m_err = 1'b0;
        end else begin
            for (int k = 0; k < 6; k++) begin
                if (m_full[k] && out_ready[k]) m_full[k] = 1'b0;
            end
            if (acc && !oob) begin
                m_full[tgt] = 1'b1;
                m_last[tgt] = in_data;
            end
            m_err = acc && oob;
            if (acc && mode) m_ptr = (m_ptr + 1) % 6;
        end
    endtask

    typedef struct {
        bit          mode;
        logic [2:0]  sel;
        logic [7:0]  data;
        bit          iv;
        bit          exp_rdy;
        logic [5:0]  exp_ov;
        bit          exp_err;
        int          exp_ch;
    } vec_t;

    vec_t tbl[8];

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        mode      = 1'b0;
        sel       = '0;
        out_ready = 6'h3F;
        for (int k = 0; k < 6; k++) begin
            m_full[k] = 1'b0;
            m_last[k] = '0;
        end
        m_ptr = 0;
        m_err = 1'b0;

        cycle();
        cycle();
        chk_en = 1'b1;
        check("reset_out_valid", 64'(out_valid), 64'h0);
        check("reset_out_data", 64'(out_data), 64'h0);
        check("reset_rr_ptr", 64'(rr_ptr), 64'h0);
        check("reset_sel_err", 64'(sel_err), 64'h0);
        check("reset_in_ready", 64'(in_ready), 64'h1);
        rst_n = 1'b1;

        tbl[0] = '{1'b0, 3'd3, 8'hA5, 1'b1, 1'b1, 6'b001000, 1'b0, 3};
        tbl[1] = '{1'b0, 3'd7, 8'h5A, 1'b1, 1'b1, 6'b000000, 1'b1, -1};
        tbl[2] = '{1'b0, 3'd6, 8'h3C, 1'b1, 1'b1, 6'b000000, 1'b1, -1};
        tbl[3] = '{1'b0, 3'd0, 8'h11, 1'b1, 1'b1, 6'b000001, 1'b0, 0};
        tbl[4] = '{1'b0, 3'd5, 8'h22, 1'b1, 1'b1, 6'b100000, 1'b0, 5};
        tbl[5] = '{1'b0, 3'd2, 8'h33, 1'b0, 1'b1, 6'b000000, 1'b0, -1};
        tbl[6] = '{1'b1, 3'd7, 8'h44, 1'b1, 1'b1, 6'b000001, 1'b0, 0};
        tbl[7] = '{1'b1, 3'd0, 8'h55, 1'b1, 1'b1, 6'b000010, 1'b0, 1};

        for (int i = 0; i < 8; i++) begin
            mode      = tbl[i].mode;
            sel       = tbl[i].sel;
            in_data   = tbl[i].data;
            in_valid  = tbl[i].iv;
            out_ready = 6'h3F;
            #1;
            check("tbl_in_ready", 64'(in_ready), 64'(tbl[i].exp_rdy));
            cycle();
            check("tbl_out_valid", 64'(out_valid), 64'(tbl[i].exp_ov));
            check("tbl_sel_err", 64'(sel_err), 64'(tbl[i].exp_err));
            if (tbl[i].exp_ch >= 0)
                check("tbl_out_data", 64'(out_data[tbl[i].exp_ch*DW +: DW]), 64'(tbl[i].data));
            in_valid = 1'b0;
            cycle();
            check("tbl_sel_err_pulse", 64'(sel_err), 64'h0);
            check("tbl_drained", 64'(out_valid), 64'h0);
        end

        // Round-robin wrap from a fresh pointer.
        rst_n = 1'b0;
        cycle();
        rst_n     = 1'b1;
        mode      = 1'b1;
        out_ready = 6'h3F;
        in_valid  = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_data = 8'h10 + 8'(i);
            cycle();
            check("rr_out_valid", 64'(out_valid), 64'(6'b1 << (i % 6)));
            check("rr_out_data", 64'(out_data[(i % 6)*DW +: DW]), 64'(8'h10 + 8'(i)));
        end
        check("rr_ptr_after_wrap", 64'(rr_ptr), 64'h1);

        // Backpressure on channel 2.
        mode      = 1'b0;
        sel       = 3'd2;
        in_data   = 8'h77;
        out_ready = 6'b000000;
        cycle();
        in_data = 8'h88;
        #1;
        check("bp_in_ready_low", 64'(in_ready), 64'h0);
        cycle();
        check("bp_hold_valid", 64'(out_valid[2]), 64'h1);
        check("bp_hold_data", 64'(out_data[2*DW +: DW]), 64'h77);
        out_ready = 6'b000100;
        #1;
        check("bp_in_ready_high", 64'(in_ready), 64'h1);
        cycle();
        check("bp_new_valid", 64'(out_valid[2]), 64'h1);
        check("bp_new_data", 64'(out_data[2*DW +: DW]), 64'h88);

        // Independence: channel 2 stays stalled while 4 and 5 take beats.
        out_ready = 6'b000000;
        sel       = 3'd4;
        in_data   = 8'h44;
        #1;
        check("indep_ready_ch4", 64'(in_ready), 64'h1);
        cycle();
        sel     = 3'd5;
        in_data = 8'h55;
        #1;
        check("indep_ready_ch5", 64'(in_ready), 64'h1);
        cycle();
        check("indep_out_valid", 64'(out_valid & 6'b110100), 64'(6'b110100));

        // Reset mid-stream with channels 1 and 4 full.
        sel     = 3'd1;
        in_data = 8'h11;
        cycle();
        check("mid_ch1_ch4_full", 64'(out_valid & 6'b010010), 64'(6'b010010));
        rst_n = 1'b0;
        sel   = 3'd3;
        #1;
        check("mid_reset_in_ready", 64'(in_ready), 64'h1);
        cycle();
        check("mid_reset_out_valid", 64'(out_valid), 64'h0);
        check("mid_reset_rr_ptr", 64'(rr_ptr), 64'h0);
        check("mid_reset_sel_err", 64'(sel_err), 64'h0);
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 6'h3F;
        cycle();
        check("mid_no_stale", 64'(out_valid), 64'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            mode      = 1'($urandom);
            sel       = 3'($urandom_range(0, 7));
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = 6'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
